// File: rtl/debug_snapshot_unit.sv
// debug_snapshot_unit
// Register-bus debug peripheral. Software arms it through CTRL; it then
// samples one word from every channel selected in CHMASK, latches the
// register-lock vector on success and signals completion in STATUS and
// on irq_o.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   reglk_ctrl_i             register-lock vector (bit0 locks CTRL/CHMASK/
//                            TIMEOUT, bit1 locks scratch words)
//   reg_valid_i/reg_write_i/reg_addr_i/reg_wdata_i/reg_wstrb_i
//                            REG_BUS request
//   reg_rdata_o/reg_ready_o/reg_error_o
//                            REG_BUS response (combinational)
//   snap_valid_i/snap_data_i per-channel snapshot inputs
//   irq_o                    completion interrupt (level)
module debug_snapshot_unit #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 64,
  parameter int LOCK_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [LOCK_WIDTH-1:0]        reglk_ctrl_i,
  input  logic                         reg_valid_i,
  input  logic                         reg_write_i,
  input  logic [ADDR_WIDTH-1:0]        reg_addr_i,
  input  logic [DATA_WIDTH-1:0]        reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      reg_wstrb_i,
  output logic [DATA_WIDTH-1:0]        reg_rdata_o,
  output logic                         reg_ready_o,
  output logic                         reg_error_o,
  input  logic [NUM_CH-1:0]            snap_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] snap_data_i,
  output logic                         irq_o
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SCR_N  = NUM_REGS - 8 - NUM_CH;
  localparam int SCR_D  = (SCR_N > 0) ? SCR_N : 1;

  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(3'd0);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(3'd1);
  localparam logic [IDX_W-1:0] IDX_CHMASK   = IDX_W'(3'd2);
  localparam logic [IDX_W-1:0] IDX_TIMEOUT  = IDX_W'(3'd3);
  localparam logic [IDX_W-1:0] IDX_LOCKSNAP = IDX_W'(3'd4);
  localparam logic [IDX_W-1:0] IDX_COUNT    = IDX_W'(3'd5);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_STORE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Byte-lane merge of a bus write into an existing register value.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [STRB_W-1:0]     wstrb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) begin
        res[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    return res;
  endfunction

  state_e                  state_r;
  logic                    irq_en_r;
  logic                    done_r;
  logic                    timeout_r;
  logic [NUM_CH-1:0]       chmask_r;
  logic [DATA_WIDTH-1:0]   tmo_cfg_r;
  logic [LOCK_WIDTH-1:0]   locksnap_r;
  logic [DATA_WIDTH-1:0]   count_r;
  logic [NUM_CH-1:0]       pending_r;
  logic [DATA_WIDTH-1:0]   timer_r;
  logic                    tmr_en_r;
  logic [DATA_WIDTH-1:0]   capture_r [NUM_CH];
  logic [DATA_WIDTH-1:0]   scratch_r [SCR_D];

  logic [IDX_W-1:0]        idx_s;
  int                      cap_sel_s;
  int                      scr_sel_s;
  logic                    is_cap_s;
  logic                    is_scr_s;
  logic                    wr_s;
  logic                    err_s;
  logic                    wr_ok_s;
  logic                    start_s;
  logic                    abort_s;
  logic                    busy_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic [DATA_WIDTH-1:0]   chmask_wr_s;
  logic [NUM_CH-1:0]       pend_next_s;
  logic                    unused_s;

  assign idx_s     = reg_addr_i[IDX_W+1:2];
  assign cap_sel_s = int'(idx_s) - 8;
  assign scr_sel_s = int'(idx_s) - 8 - NUM_CH;
  assign is_cap_s  = (int'(idx_s) >= 8) && (int'(idx_s) < 8 + NUM_CH);
  assign is_scr_s  = (int'(idx_s) >= 8 + NUM_CH);
  assign wr_s      = reg_valid_i & reg_write_i;
  assign busy_s    = (state_r == ST_ARM) || (state_r == ST_CAPTURE) || (state_r == ST_STORE);
  assign unused_s  = ^{reg_addr_i[ADDR_WIDTH-1:IDX_W+2], reg_addr_i[1:0]};

  // Read mux and access-error decode for the addressed word.
  always_comb begin
    rdata_s = '0;
    err_s   = 1'b0;
    if (idx_s == IDX_CTRL) begin
      rdata_s[2] = irq_en_r;
      err_s      = wr_s & reglk_ctrl_i[0];
    end else if (idx_s == IDX_STATUS) begin
      rdata_s[2:0] = state_r;
      rdata_s[4]   = busy_s;
      rdata_s[5]   = done_r;
      rdata_s[6]   = timeout_r;
      err_s        = wr_s;
    end else if (idx_s == IDX_CHMASK) begin
      rdata_s[NUM_CH-1:0] = chmask_r;
      err_s               = wr_s & (reglk_ctrl_i[0] | busy_s);
    end else if (idx_s == IDX_TIMEOUT) begin
      rdata_s = tmo_cfg_r;
      err_s   = wr_s & (reglk_ctrl_i[0] | busy_s);
    end else if (idx_s == IDX_LOCKSNAP) begin
      rdata_s[LOCK_WIDTH-1:0] = locksnap_r;
      err_s                   = wr_s;
    end else if (idx_s == IDX_COUNT) begin
      rdata_s = count_r;
      err_s   = wr_s;
    end else if (is_cap_s) begin
      rdata_s = capture_r[cap_sel_s];
      err_s   = wr_s;
    end else if (is_scr_s) begin
      rdata_s = scratch_r[scr_sel_s];
      err_s   = wr_s & reglk_ctrl_i[1];
    end else begin
      // reserved words 6 and 7
      err_s = wr_s;
    end
  end

  // Accepted-write qualifiers and the CTRL command pulses (byte 0 only).
  always_comb begin
    wr_ok_s     = wr_s & ~err_s;
    start_s     = wr_ok_s & (idx_s == IDX_CTRL) & reg_wstrb_i[0] & reg_wdata_i[0];
    abort_s     = wr_ok_s & (idx_s == IDX_CTRL) & reg_wstrb_i[0] & reg_wdata_i[1];
    chmask_wr_s = merge_bytes(DATA_WIDTH'(chmask_r), reg_wdata_i, reg_wstrb_i);
    pend_next_s = pending_r & ~snap_valid_i;
  end

  assign reg_rdata_o = rdata_s;
  assign reg_ready_o = 1'b1;
  assign reg_error_o = err_s;
  assign irq_o       = done_r & irq_en_r;

  // Software-writable configuration and scratch words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_r  <= 1'b0;
      chmask_r  <= '0;
      tmo_cfg_r <= '0;
      for (int i = 0; i < SCR_D; i++) begin
        scratch_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      if (idx_s == IDX_CTRL) begin
        if (reg_wstrb_i[0]) begin
          irq_en_r <= reg_wdata_i[2];
        end
      end else if (idx_s == IDX_CHMASK) begin
        chmask_r <= chmask_wr_s[NUM_CH-1:0];
      end else if (idx_s == IDX_TIMEOUT) begin
        tmo_cfg_r <= merge_bytes(tmo_cfg_r, reg_wdata_i, reg_wstrb_i);
      end else if (is_scr_s) begin
        scratch_r[scr_sel_s] <= merge_bytes(scratch_r[scr_sel_s], reg_wdata_i, reg_wstrb_i);
      end
    end
  end

  // Snapshot sequencer with capture, status and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      pending_r  <= '0;
      timer_r    <= '0;
      tmr_en_r   <= 1'b0;
      locksnap_r <= '0;
      count_r    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        capture_r[c] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s && (chmask_r != '0)) begin
            state_r <= ST_ARM;
          end
        end
        ST_ARM: begin
          done_r    <= 1'b0;
          timeout_r <= 1'b0;
          if (abort_s) begin
            pending_r <= '0;
            state_r   <= ST_IDLE;
          end else begin
            pending_r <= chmask_r;
            timer_r   <= tmo_cfg_r;
            tmr_en_r  <= (tmo_cfg_r != '0);
            state_r   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (pending_r[c] && snap_valid_i[c]) begin
              capture_r[c] <= snap_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          pending_r <= pend_next_s;
          if (tmr_en_r) begin
            timer_r <= timer_r - DATA_WIDTH'(1'b1);
          end
          // Priority: abort, then completion, then timer expiry.
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else if (pend_next_s == '0) begin
            state_r <= ST_STORE;
          end else if (tmr_en_r && (timer_r == DATA_WIDTH'(1'b1))) begin
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_STORE: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else begin
            locksnap_r <= reglk_ctrl_i;
            count_r    <= count_r + DATA_WIDTH'(1'b1);
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (abort_s) begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (start_s) begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            state_r   <= ST_ARM;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_snapshot_unit.sv
`timescale 1ns/1ps
// Directed and randomized bench for debug_snapshot_unit using a
// transaction-level expectation model (per-snapshot outcome arithmetic).
module tb_debug_snapshot_unit;

  localparam int NCH = 4;
  localparam int W_CTRL = 0, W_STATUS = 1, W_CHMASK = 2, W_TIMEOUT = 3;
  localparam int W_LOCK = 4, W_COUNT = 5, W_CAP0 = 8, W_SCR = 20;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [7:0]     reglk_ctrl_i = 8'h00;
  logic           reg_valid_i = 1'b0;
  logic           reg_write_i = 1'b0;
  logic [31:0]    reg_addr_i = 32'h0;
  logic [31:0]    reg_wdata_i = 32'h0;
  logic [3:0]     reg_wstrb_i = 4'h0;
  logic [31:0]    reg_rdata_o;
  logic           reg_ready_o;
  logic           reg_error_o;
  logic [NCH-1:0] snap_valid_i = '0;
  logic [NCH*32-1:0] snap_data_i = '0;
  logic           irq_o;

  int nvec = 0;
  int nerr = 0;

  debug_snapshot_unit dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .reglk_ctrl_i (reglk_ctrl_i),
    .reg_valid_i  (reg_valid_i),
    .reg_write_i  (reg_write_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wstrb_i  (reg_wstrb_i),
    .reg_rdata_o  (reg_rdata_o),
    .reg_ready_o  (reg_ready_o),
    .reg_error_o  (reg_error_o),
    .snap_valid_i (snap_valid_i),
    .snap_data_i  (snap_data_i),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input int w, output logic [31:0] d);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b0;
    reg_addr_i  = 32'(w * 4);
    #1;
    d = reg_rdata_o;
    reg_valid_i = 1'b0;
  endtask

  task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s, output logic e);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b1;
    reg_addr_i  = 32'(w * 4);
    reg_wdata_i = d;
    reg_wstrb_i = s;
    #1;
    e = reg_error_o;
    @(posedge clk_i);
    #1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] mcap [NCH];
    logic [31:0] mcount;
    logic [7:0]  mlock;
    logic [7:0]  lk;
    logic [3:0]  mask;
    logic        ien;
    logic        all_ok;
    int          n, last, done_cyc, cur, k;
    int          off [NCH];
    logic [31:0] dat [NCH];

    for (int c = 0; c < NCH; c++) mcap[c] = 32'h0;
    mcount = 32'h0;
    mlock  = 8'h00;

    // ---- reset: every word reads zero, STATUS is read-only ----
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    check("reset_err", {31'h0, reg_error_o}, 32'h0);
    check("ready", {31'h0, reg_ready_o}, 32'h1);
    for (int w = 0; w < 64; w++) begin
      rd(w, d);
      check($sformatf("reset_word%0d", w), d, 32'h0);
    end
    tick();
    wr(W_STATUS, 32'hFFFF_FFFF, 4'hF, e);
    check("status_wr_err", {31'h0, e}, 32'h1);
    rd(W_STATUS, d);
    check("status_unchanged", d, 32'h0);

    // ---- two-channel snapshot with staggered valids ----
    lk = 8'($urandom) & 8'hFC;
    reglk_ctrl_i = lk;
    wr(W_CHMASK, 32'h5, 4'hF, e);
    check("chmask_wr_ok", {31'h0, e}, 32'h0);
    wr(W_CTRL, 32'h1, 4'hF, e);           // cycle t
    rd(W_STATUS, d);
    check("t1_arm", d, 32'h11);
    tick();                               // t+2
    rd(W_STATUS, d);
    check("t2_capture", d, 32'h12);
    snap_valid_i = 4'b0001;
    snap_data_i[0 +: 32] = 32'hA5A5_0000;
    tick();                               // t+3
    snap_valid_i = 4'b0000;
    tick();                               // t+4
    snap_valid_i = 4'b0100;
    snap_data_i[64 +: 32] = 32'h1234_5678;
    tick();                               // t+5
    snap_valid_i = 4'b0000;
    rd(W_STATUS, d);
    check("t5_store", d, 32'h13);
    tick();                               // t+6
    rd(W_STATUS, d);
    check("t6_done", d, 32'h24);
    mcap[0] = 32'hA5A5_0000;
    mcap[2] = 32'h1234_5678;
    mcount  = 32'h1;
    mlock   = lk;
    for (int c = 0; c < NCH; c++) begin
      rd(W_CAP0 + c, d);
      check($sformatf("dir_cap%0d", c), d, mcap[c]);
    end
    rd(W_COUNT, d);
    check("dir_count", d, mcount);
    rd(W_LOCK, d);
    check("dir_locksnap", d, {24'h0, mlock});
    check("dir_irq_off", {31'h0, irq_o}, 32'h0);

    // ---- timeout with no valid data ----
    wr(W_TIMEOUT, 32'h5, 4'hF, e);
    wr(W_CHMASK, 32'h1, 4'hF, e);
    wr(W_CTRL, 32'h1, 4'hF, e);           // t (re-arm from DONE)
    repeat (5) tick();                    // t+6
    rd(W_STATUS, d);
    check("to_t6_capture", d, 32'h12);
    tick();                               // t+7
    rd(W_STATUS, d);
    check("to_t7_done", d, 32'h64);
    rd(W_COUNT, d);
    check("to_count", d, mcount);

    // ---- interrupt enable and abort from DONE ----
    wr(W_CTRL, 32'h4, 4'hF, e);
    check("irq_on", {31'h0, irq_o}, 32'h1);
    wr(W_CTRL, 32'h6, 4'hF, e);
    check("irq_cleared", {31'h0, irq_o}, 32'h0);
    rd(W_STATUS, d);
    check("abort_idle", d, 32'h0);
    rd(W_CTRL, d);
    check("ctrl_rd", d, 32'h4);

    // ---- randomized snapshots against the outcome model ----
    for (int it = 0; it < 24; it++) begin
      mask = 4'($urandom_range(1, 15));
      n    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      lk   = 8'($urandom) & 8'hFC;
      ien  = 1'($urandom_range(0, 1));
      reglk_ctrl_i = lk;
      for (int c = 0; c < NCH; c++) begin
        off[c] = int'($urandom_range(0, 6));
        dat[c] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wr(W_CTRL, 32'h2, 4'h1, e);
      wr(W_CHMASK, {28'h0, mask}, 4'hF, e);
      wr(W_TIMEOUT, 32'(n), 4'hF, e);
      // outcome: all selected channels arrive inside the window -> normal
      all_ok = 1'b1;
      last   = 0;
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          if (n != 0 && off[c] >= n) all_ok = 1'b0;
          if (off[c] > last) last = off[c];
        end
      end
      done_cyc = all_ok ? last + 4 : n + 2;
      wr(W_CTRL, {29'h0, ien, 2'b01}, 4'hF, e);
      cur = 1;
      rd(W_STATUS, d);
      check("rnd_arm", d, 32'h11);
      while (cur < done_cyc) begin
        tick();
        cur++;
        rd(W_STATUS, d);
        if (cur == done_cyc) check("rnd_done_status", d, all_ok ? 32'h24 : 32'h64);
        else if (cur == done_cyc - 1) check("rnd_busy", {31'h0, d[4]}, 32'h1);
        k = cur - 2;
        for (int c = 0; c < NCH; c++) begin
          if (mask[c]) begin
            snap_valid_i[c] = (off[c] == k);
            snap_data_i[c*32 +: 32] = dat[c];
          end else begin
            snap_valid_i[c] = 1'($urandom_range(0, 1));
            snap_data_i[c*32 +: 32] = $urandom;
          end
        end
      end
      snap_valid_i = '0;
      for (int c = 0; c < NCH; c++) begin
        if (mask[c] && (n == 0 || off[c] < n)) mcap[c] = dat[c];
      end
      if (all_ok) begin
        mcount = mcount + 32'h1;
        mlock  = lk;
      end
      for (int c = 0; c < NCH; c++) begin
        rd(W_CAP0 + c, d);
        check($sformatf("rnd%0d_cap%0d", it, c), d, mcap[c]);
      end
      rd(W_COUNT, d);
      check("rnd_count", d, mcount);
      rd(W_LOCK, d);
      check("rnd_locksnap", d, {24'h0, mlock});
      check("rnd_irq", {31'h0, irq_o}, {31'h0, ien});
    end

    // ---- register locks and byte strobes ----
    reglk_ctrl_i = 8'h00;
    wr(W_CTRL, 32'h2, 4'hF, e);
    wr(W_CHMASK, 32'h3, 4'hF, e);
    wr(W_SCR, 32'h1122_3344, 4'hF, e);
    reglk_ctrl_i = 8'h01;
    wr(W_CHMASK, 32'hF, 4'hF, e);
    check("lock_chmask_err", {31'h0, e}, 32'h1);
    rd(W_CHMASK, d);
    check("lock_chmask_val", d, 32'h3);
    wr(W_CTRL, 32'h1, 4'hF, e);
    check("lock_ctrl_err", {31'h0, e}, 32'h1);
    rd(W_STATUS, d);
    check("lock_no_start", d, 32'h0);
    wr(W_SCR, 32'hAABB_CCDD, 4'b0010, e);
    check("scr_strb_err", {31'h0, e}, 32'h0);
    rd(W_SCR, d);
    check("scr_strb_val", d, 32'h1122_CC44);
    reglk_ctrl_i = 8'h02;
    wr(W_SCR, 32'h0, 4'hF, e);
    check("lock_scr_err", {31'h0, e}, 32'h1);
    rd(W_SCR, d);
    check("lock_scr_val", d, 32'h1122_CC44);
    reglk_ctrl_i = 8'h00;

    // ---- abort coincident with the last capture ----
    wr(W_CHMASK, 32'h1, 4'hF, e);
    wr(W_TIMEOUT, 32'h0, 4'hF, e);
    wr(W_CTRL, 32'h1, 4'hF, e);           // t
    wr(W_CHMASK, 32'h2, 4'hF, e);         // t+1, busy
    check("busy_chmask_err", {31'h0, e}, 32'h1);
    snap_valid_i = 4'b0001;               // t+2
    snap_data_i[0 +: 32] = 32'hDEAD_BEEF;
    wr(W_CTRL, 32'h2, 4'hF, e);
    snap_valid_i = '0;
    rd(W_STATUS, d);
    check("abort_cap_idle", d, 32'h0);
    rd(W_CAP0, d);
    check("abort_cap_data", d, 32'hDEAD_BEEF);
    rd(W_COUNT, d);
    check("abort_cap_count", d, mcount);
    rd(W_CHMASK, d);
    check("busy_chmask_val", d, 32'h1);

    // ---- asynchronous reset in the middle of CAPTURE ----
    wr(W_CTRL, 32'h1, 4'hF, e);
    tick();
    rd(W_STATUS, d);
    check("pre_rst_capture", d, 32'h12);
    rst_ni = 1'b0;
    #1;
    rd(W_STATUS, d);
    check("rst_status", d, 32'h0);
    rd(W_COUNT, d);
    check("rst_count", d, 32'h0);
    rd(W_CAP0, d);
    check("rst_cap0", d, 32'h0);
    rd(W_CHMASK, d);
    check("rst_chmask", d, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    tick();
    rst_ni = 1'b1;
    for (int w = 0; w < 64; w++) begin
      rd(w, d);
      check($sformatf("rst2_word%0d", w), d, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/debug_snapshot_unit.md
# debug_snapshot_unit

Register-bus debug peripheral that arms on a software command, captures one data word from each enabled snapshot channel, latches the current register-lock vector, and reports completion by status and interrupt. It sits on the peripheral REG_BUS next to the existing debug peripherals. It generalises the fixed single-word load/store debug sequencer with parameterised channel count and register depth, a timeout, an abort path, lock-enforced writes, and bus error reporting.

## Interface
- NUM_CH, 4: snapshot channels (1..16).
- DATA_WIDTH, 32: bus and capture word width.
- ADDR_WIDTH, 32: bus address width.
- NUM_REGS, 64: total word registers (power of 2, ≥ 8+NUM_CH).
- LOCK_WIDTH, 8: register-lock vector width.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- reglk_ctrl_i  in  LOCK_WIDTH  register-lock values.
- reg_valid_i  in  1  bus access valid.
- reg_write_i  in  1  1=write, 0=read.
- reg_addr_i  in  ADDR_WIDTH  byte address; word index = addr[log2(NUM_REGS)+1:2].
- reg_wdata_i  in  DATA_WIDTH  write data.
- reg_wstrb_i  in  DATA_WIDTH/8  byte strobes.
- reg_rdata_o  out  DATA_WIDTH  read data, combinational.
- reg_ready_o  out  1  tied 1.
- reg_error_o  out  1  combinational access error.
- snap_valid_i  in  NUM_CH  per-channel data valid.
- snap_data_i  in  NUM_CH*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- irq_o  out  1  completion interrupt, level.

## Operation
- Word map: 0 CTRL (W: bit0 start, bit1 abort/clear, bit2 irq_en; read returns irq_en in bit2, others 0). 1 STATUS (RO: [2:0] state, bit4 busy, bit5 done, bit6 timeout). 2 CHMASK (RW, [NUM_CH-1:0]). 3 TIMEOUT (RW, cycles, 0 = none). 4 LOCKSNAP (RO). 5 COUNT (RO, completed snapshots, wraps at 2^DATA_WIDTH). 6-7 reserved (read 0). 8..8+NUM_CH-1 CAPTURE[c] (RO). Remainder: scratch (RW).
- Error (write ignored, reg_error_o=1 while reg_valid_i): write to RO/reserved; write to CTRL/CHMASK/TIMEOUT while reglk_ctrl_i[0]=1; write to scratch while reglk_ctrl_i[1]=1; write to CHMASK/TIMEOUT while busy. Reads never error; reserved reads return 0.
- Writes honour reg_wstrb_i per byte (CTRL acts on byte 0 only).
- States: IDLE=0, ARM=1, CAPTURE=2, STORE=3, DONE=4.
- IDLE: start with CHMASK≠0 → ARM; start with CHMASK=0 is ignored.
- ARM: clear pending/done/timeout, pending=CHMASK, timer=TIMEOUT → CAPTURE.
- CAPTURE: per cycle, each pending channel with snap_valid_i captures data into CAPTURE[c] and clears its pending bit. When no bits remain pending → STORE. If TIMEOUT≠0, timer decrements each CAPTURE cycle; on reaching 0 with bits still pending → DONE with timeout=1, no COUNT increment, LOCKSNAP unchanged.
- STORE: LOCKSNAP=reglk_ctrl_i, COUNT+1 → DONE.
- DONE: done=1; irq_o=done&irq_en. Start → ARM (re-arm). Abort → IDLE, done/timeout cleared.
- Abort in ARM/CAPTURE/STORE → IDLE; captures already taken are kept; no COUNT increment.
- busy = state ∈ {ARM, CAPTURE, STORE}. Start while busy is ignored, no error.

## Timing
- Reset: state IDLE, all registers 0, reg_error_o=0, irq_o=0, reg_rdata_o=0 (index 0 reads 0).
- Start written in cycle t → ARM at t+1, CAPTURE at t+2; the first sampling cycle is t+2.
- All pending channels cleared in cycle c → STORE at c+1, DONE and irq_o at c+2.
- Timeout: with TIMEOUT=N, the final CAPTURE cycle is t+N+1 and DONE is at t+N+2.
- Simultaneous abort and last capture: abort wins; the capture is written and state goes to IDLE.
- A channel capture and a timeout in the same cycle: the capture is written, then completion is evaluated; if all channels are done → STORE.
- Bus reads are combinational and reflect register state at the current cycle.

## Test plan
- Reset, then read all words → 0; write STATUS → reg_error_o=1 and value unchanged.
- CHMASK=0b0101, start; ch0 valid with 0xA5A5_0000 at t+2, ch2 valid with 0x1234_5678 at t+4 → DONE at t+6, CAPTURE0/2 hold those values, COUNT=1, LOCKSNAP=reglk_ctrl_i.
- TIMEOUT=5, CHMASK=0b1, no valid → STATUS timeout=1, state=4 at t+7; COUNT unchanged.
- irq_en=1 with a completed snapshot → irq_o=1; write abort → irq_o=0 next cycle, state IDLE.
- reglk_ctrl_i=0x01: write CHMASK → error, CHMASK unchanged; write scratch with wstrb=0b0010 → only byte1 updated.
- Abort in CAPTURE coincident with the last valid → data captured, state IDLE, COUNT unchanged; assert rst_ni mid-CAPTURE → all registers 0 immediately.
